button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
//
// PURPOSE
// Conditions one raw, bouncing push-button input into clean control strobes
// for the 8-bit counter that drives the board LEDs.
// - Synchronises the asynchronous button to clock.
// - Debounces it with a state machine and a cycle counter.
// - Emits a debounced level plus one-cycle press and release pulses.
// - Instantiated once per button (count, clear) between the board pins and the counter.
//
// PARAMETERS
// ACTIVE_LOW      1     1: raw button reads 0 when pressed (board default); 0: reads 1 when pressed
// DEBOUNCE_CYCLES 1000  consecutive stable synchronised samples required to accept a change; legal range >=2
// CNT_WIDTH       20    width of the debounce and repeat counters; 2**CNT_WIDTH must exceed every cycle parameter
// REPEAT_DELAY    500   hold time, in cycles after press_o, before the first auto-repeat pulse (AUTOREPEAT_EN only)
// REPEAT_PERIOD   250   cycles between subsequent auto-repeat pulses; legal range >=1 (AUTOREPEAT_EN only)
//
// PORTS
// clock      in   1  single system clock; all flops are rising-edge
// clear      in   1  asynchronous, active-high reset
// btn_i      in   1  raw button pin; asynchronous to clock, may bounce
// level_o    out  1  debounced state; 1 = pressed, independent of ACTIVE_LOW
// press_o    out  1  one-cycle pulse on each accepted press (plus auto-repeats when enabled)
// release_o  out  1  one-cycle pulse on each accepted release
//
// BEHAVIOUR
// - Synchroniser: two flops on btn_i, preset by clear to the inactive level (ACTIVE_LOW).
//   p = sync2 XOR ACTIVE_LOW; p = 1 means pressed.
// - FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE. cnt is CNT_WIDTH bits and saturates; it never wraps.
// - IDLE: if p=1, go to DB_PRESS with cnt=0.
// - DB_PRESS:
//   - p=0: return to IDLE; this is a bounce, no pulse.
//   - p=1 and cnt=DEBOUNCE_CYCLES-1: go to PRESSED and register press_o=1.
//   - otherwise p=1: cnt+1.
// - PRESSED: if p=0, go to DB_RELEASE with cnt=0.
// - DB_RELEASE:
//   - p=1: return to PRESSED; no pulse.
//   - p=0 and cnt=DEBOUNCE_CYCLES-1: go to IDLE and register release_o=1.
//   - otherwise p=0: cnt+1.
// - level_o = 1 in PRESSED and DB_RELEASE, 0 in IDLE and DB_PRESS. It is registered and changes in the
//   same cycle as the corresponding pulse.
// - Latency: if edge k is the first to sample a new stable btn_i, level_o and the pulse are high
//   after edge k+DEBOUNCE_CYCLES+2. All outputs are registered; no combinational path from btn_i.
// - press_o and release_o are never high in the same cycle; each is exactly one cycle wide.
// - Reset values: level_o=0, press_o=0, release_o=0, state=IDLE, cnt=0, synchroniser=inactive.
// - Reset mid-operation: all outputs drop immediately (asynchronously) and no pulse is emitted.
//   A button held through deassertion of clear is then detected as a fresh press after full debounce.
//
// CONFIGURATION
// AUTOREPEAT_EN defined:
// - While in PRESSED, a repeat counter runs. It is zeroed on entry from DB_PRESS.
// - It holds its value during DB_RELEASE and resumes if the state returns to PRESSED.
// - press_o pulses again REPEAT_DELAY cycles after the initial press_o, then every REPEAT_PERIOD cycles.
// - Auto-repeat stops on entry to IDLE.
// AUTOREPEAT_EN undefined:
// - There is no repeat logic and REPEAT_* are ignored; press_o pulses exactly once per accepted press.
//
// TESTING (bench: DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=5)
// - Clean press: btn_i 1->0 first sampled at edge k and held -> level_o=1 and a single press_o pulse
//   after edge k+6.
// - Bounce: btn_i 0 for 3 cycles, 1 for 1 cycle, then 0 held -> no pulse during the bounce; press_o
//   after edge f+6, where f is the edge first sampling the final fall.
// - Release: from PRESSED, btn_i 0->1 held -> single release_o pulse, level_o=0, after edge r+6;
//   a 2-cycle release glitch produces no pulse.
// - Reset mid-debounce: assert clear while in DB_PRESS -> outputs 0 immediately. Deassert clear with
//   btn_i held low -> press_o after 6 edges.
// - Auto-repeat (AUTOREPEAT_EN): hold for 30 cycles after press_o at cycle P -> extra press_o pulses
//   at P+10, P+15, P+20, P+25.
// - Without AUTOREPEAT_EN: the same hold gives exactly one press_o pulse.

Source files
------------

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Turns one raw, bouncing push-button pin into clean strobes.
//               Two-flop synchroniser, four-state debounce FSM with a
//               saturating cycle counter, registered level / press / release.
//               Optional auto-repeat of press_o while the button is held,
//               enabled by defining the macro AUTOREPEAT_EN.
// Ports       : clock      in  system clock, rising edge
//               clear      in  asynchronous active-high reset
//               btn_i      in  raw button pin (asynchronous, may bounce)
//               level_o    out debounced state, 1 = pressed
//               press_o    out one-cycle pulse per accepted press (+ repeats)
//               release_o  out one-cycle pulse per accepted release
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic clock,
  input  logic clear,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  // Idle level of the raw pin; the synchroniser is preset to it.
  localparam logic                 C_INACTIVE = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] C_DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = {CNT_WIDTH{1'b1}};

  localparam logic [1:0] C_IDLE       = 2'd0;
  localparam logic [1:0] C_DB_PRESS   = 2'd1;
  localparam logic [1:0] C_PRESSED    = 2'd2;
  localparam logic [1:0] C_DB_RELEASE = 2'd3;

  logic [1:0]           sync_q, sync_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 pressed;

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  // Normalised to 1 = pressed regardless of pin polarity.
  assign pressed = sync_q[1] ^ C_INACTIVE;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_q    <= {2{C_INACTIVE}};
      state_q   <= C_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (pressed) begin
          state_d = C_DB_PRESS;
          cnt_d   = '0;
        end
      end
      C_DB_PRESS: begin
        if (!pressed) begin
          state_d = C_IDLE;
        end else if (cnt_q == C_DB_LAST) begin
          state_d = C_PRESSED;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      C_PRESSED: begin
        if (!pressed) begin
          state_d = C_DB_RELEASE;
          cnt_d   = '0;
        end
      end
      C_DB_RELEASE: begin
        if (pressed) begin
          state_d = C_PRESSED;
        end else if (cnt_q == C_DB_LAST) begin
          state_d = C_IDLE;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTOREPEAT_EN
  // --------------------------------------------------------------------------
  // Auto-repeat: counts cycles spent in PRESSED. Before the first repeat it
  // compares against the initial delay, afterwards against the period; it is
  // cleared on every fire so it never needs to wrap.
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic                 rep_armed_q, rep_armed_d;
  logic                 rep_fire;

  localparam logic [CNT_WIDTH-1:0] C_REP_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] C_REP_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = (state_q == C_PRESSED) &&
                  (rep_cnt_q == (rep_armed_q ? C_REP_PERIOD_LAST : C_REP_DELAY_LAST));
    if ((state_q == C_DB_PRESS) && (state_d == C_PRESSED)) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (state_d == C_IDLE) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (state_q == C_PRESSED) begin
      if (rep_fire) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else if (rep_cnt_q != C_CNT_MAX) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
    // DB_RELEASE falls through: the counter holds and resumes on return.
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Output logic: decoded from the transition so the registered level and
  // pulse change on the same edge as the state.
  // --------------------------------------------------------------------------
  always_comb begin
    level_d   = (state_d == C_PRESSED) || (state_d == C_DB_RELEASE);
    press_d   = (state_q == C_DB_PRESS) && (state_d == C_PRESSED);
    release_d = (state_q == C_DB_RELEASE) && (state_d == C_IDLE);
`ifdef AUTOREPEAT_EN
    press_d   = press_d | rep_fire;
`else
    press_d   = press_d;
`endif
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10,
//               REPEAT_PERIOD=5. Expected repeat behaviour follows the
//               AUTOREPEAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

`ifdef AUTOREPEAT_EN
  localparam bit C_AR = 1'b1;
`else
  localparam bit C_AR = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear;
  logic btn_i;
  logic level_o;
  logic press_o;
  logic release_o;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (8),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .btn_i     (btn_i),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Button already driven; expects press 6 edges of silence then pulse.
  task automatic expect_press(input string tag);
    for (int i = 1; i <= 6; i++) begin
      step();
      check({tag, "_early_press"}, press_o, 0);
      check({tag, "_early_level"}, level_o, 0);
    end
    step();
    check({tag, "_press"}, press_o, 1);
    check({tag, "_level"}, level_o, 1);
    check({tag, "_no_release"}, release_o, 0);
  endtask

  task automatic expect_release(input string tag);
    for (int i = 1; i <= 6; i++) begin
      step();
      check({tag, "_early_release"}, release_o, 0);
      check({tag, "_early_level"}, level_o, 1);
    end
    step();
    check({tag, "_release"}, release_o, 1);
    check({tag, "_level"}, level_o, 0);
    check({tag, "_no_press"}, press_o, 0);
    step();
    check({tag, "_release_width"}, release_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    btn_i = 1'b1;
    #12;
    check("rst_level", level_o, 0);
    check("rst_press", press_o, 0);
    check("rst_release", release_o, 0);
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_level", level_o, 0);
    end

    // Clean press, then hold to observe (or rule out) auto-repeat.
    btn_i = 1'b0;
    expect_press("clean");
    for (int j = 1; j <= 29; j++) begin
      step();
      check("hold_press", press_o,
            (C_AR && j >= 10 && ((j - 10) % 5) == 0) ? 1 : 0);
      check("hold_release", release_o, 0);
      check("hold_level", level_o, 1);
    end

    // Two-cycle release glitch: stays pressed, no release pulse.
    btn_i = 1'b1;
    step();
    step();
    btn_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch_release", release_o, 0);
      check("glitch_level", level_o, 1);
    end

    // Clean release.
    btn_i = 1'b1;
    expect_release("rel1");
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle2_press", press_o, 0);
    end

    // Bouncing press: 0 x3, 1 x1, then 0 held.
    btn_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bounce_press", press_o, 0);
    end
    btn_i = 1'b1;
    step();
    check("bounce_press", press_o, 0);
    btn_i = 1'b0;
    expect_press("bounce");

    // Reset while a press pulse and level are high: both drop at once.
    #2;
    clear = 1'b1;
    #1;
    check("rst_pressed_level", level_o, 0);
    check("rst_pressed_press", press_o, 0);
    check("rst_pressed_release", release_o, 0);
    step();
    step();
    check("rst_hold_level", level_o, 0);
    clear = 1'b0;
    expect_press("after_rst");

    // Reset in the middle of press debounce.
    btn_i = 1'b1;
    expect_release("rel2");
    btn_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dbp_press", press_o, 0);
    end
    #2;
    clear = 1'b1;
    #1;
    check("rst_db_level", level_o, 0);
    check("rst_db_press", press_o, 0);
    check("rst_db_release", release_o, 0);
    step();
    clear = 1'b0;
    expect_press("after_rst_db");
    step();
    check("press_width", press_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
